// File: rtl/ssio_sdr_rx_capture.sv
// Source-synchronous SDR receive capture: strips preamble/SFD and streams payload bytes.
// Optional statistics counters are built when SSIO_SDR_RX_STATS_EN is defined.
module ssio_sdr_rx_capture #(
  parameter int                 WIDTH        = 8,
  parameter logic [WIDTH-1:0]   SFD          = 8'hD5,
  parameter int                 MIN_PREAMBLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_d,
  input  logic             input_dv,
  input  logic             input_er,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic [15:0]      stat_frame_count,
  output logic [15:0]      stat_bad_frame_count,
  output logic [15:0]      stat_preamble_err_count
);

  localparam logic [1:0]       ST_IDLE     = 2'd0;
  localparam logic [1:0]       ST_PREAMBLE = 2'd1;
  localparam logic [1:0]       ST_PAYLOAD  = 2'd2;
  localparam logic [1:0]       ST_DROP     = 2'd3;
  localparam logic [WIDTH-1:0] PRE_BYTE    = WIDTH'(8'h55);
  localparam logic [2:0]       MIN_PRE_C   = 3'(MIN_PREAMBLE);

  (* IOB = "TRUE" *) logic [WIDTH-1:0] d_q;
  (* IOB = "TRUE" *) logic             dv_q;
  (* IOB = "TRUE" *) logic             er_q;

  logic [1:0]       state_r, state_s;
  logic [2:0]       cnt_r, cnt_s;
  logic [WIDTH-1:0] hold_r, hold_s;
  logic             hold_full_r, hold_full_s;
  logic             err_acc_r, err_acc_s;
  logic             out_valid_s, out_last_s, out_user_s;
  logic [WIDTH-1:0] out_data_s;

  // Next-state and output decode; the one-byte hold delays emission so tlast lands on the final byte.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    err_acc_s   = err_acc_r;
    out_valid_s = 1'b0;
    out_last_s  = 1'b0;
    out_user_s  = 1'b0;
    out_data_s  = hold_r;
    case (state_r)
      ST_IDLE: begin
        if (!dv_q) begin
          state_s = ST_IDLE;
        end else if (d_q == PRE_BYTE) begin
          state_s = ST_PREAMBLE;
          cnt_s   = 3'd1;
        end else if ((d_q == SFD) && (MIN_PRE_C == 3'd0)) begin
          state_s     = ST_PAYLOAD;
          err_acc_s   = 1'b0;
          hold_full_s = 1'b0;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!dv_q) begin
          state_s = ST_IDLE;
        end else if (d_q == PRE_BYTE) begin
          if (cnt_r != 3'd7) begin
            cnt_s = cnt_r + 3'd1;
          end else begin
            cnt_s = cnt_r;
          end
        end else if ((d_q == SFD) && (cnt_r >= MIN_PRE_C)) begin
          state_s     = ST_PAYLOAD;
          err_acc_s   = 1'b0;
          hold_full_s = 1'b0;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_PAYLOAD: begin
        if (dv_q) begin
          out_valid_s = hold_full_r;
          hold_s      = d_q;
          hold_full_s = 1'b1;
          if (er_q) begin
            err_acc_s = 1'b1;
          end else begin
            err_acc_s = err_acc_r;
          end
        end else begin
          out_valid_s = hold_full_r;
          out_last_s  = hold_full_r;
          out_user_s  = hold_full_r & err_acc_r;
          hold_full_s = 1'b0;
          state_s     = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!dv_q) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Pad capture, FSM state and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q           <= '0;
      dv_q          <= 1'b0;
      er_q          <= 1'b0;
      state_r       <= ST_IDLE;
      cnt_r         <= 3'd0;
      hold_r        <= '0;
      hold_full_r   <= 1'b0;
      err_acc_r     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      d_q           <= input_d;
      dv_q          <= input_dv;
      er_q          <= input_er;
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      hold_r        <= hold_s;
      hold_full_r   <= hold_full_s;
      err_acc_r     <= err_acc_s;
      m_axis_tdata  <= out_valid_s ? out_data_s : '0;
      m_axis_tvalid <= out_valid_s;
      m_axis_tlast  <= out_last_s;
      m_axis_tuser  <= out_user_s;
    end
  end

`ifdef SSIO_SDR_RX_STATS_EN
  logic        pre_err_s, empty_s;
  logic        good_evt_r, bad_evt_r, pre_evt_r;
  logic [15:0] frame_cnt_r, bad_cnt_r, pre_cnt_r;

  // Preamble error: any entry into DROP, or carrier lost during the preamble.
  assign pre_err_s = ((state_s == ST_DROP) && (state_r != ST_DROP)) ||
                     ((state_r == ST_PREAMBLE) && !dv_q);
  assign empty_s   = (state_r == ST_PAYLOAD) && !dv_q && !hold_full_r;

  // Events are registered so counters move the cycle after the tlast/error they record.
  always_ff @(posedge clk) begin
    if (rst) begin
      good_evt_r  <= 1'b0;
      bad_evt_r   <= 1'b0;
      pre_evt_r   <= 1'b0;
      frame_cnt_r <= 16'd0;
      bad_cnt_r   <= 16'd0;
      pre_cnt_r   <= 16'd0;
    end else begin
      good_evt_r <= out_valid_s & out_last_s & ~out_user_s;
      bad_evt_r  <= (out_valid_s & out_last_s & out_user_s) | empty_s;
      pre_evt_r  <= pre_err_s;
      if (good_evt_r && (frame_cnt_r != 16'hFFFF)) frame_cnt_r <= frame_cnt_r + 16'd1;
      if (bad_evt_r && (bad_cnt_r != 16'hFFFF))    bad_cnt_r   <= bad_cnt_r + 16'd1;
      if (pre_evt_r && (pre_cnt_r != 16'hFFFF))    pre_cnt_r   <= pre_cnt_r + 16'd1;
    end
  end

  assign stat_frame_count        = frame_cnt_r;
  assign stat_bad_frame_count    = bad_cnt_r;
  assign stat_preamble_err_count = pre_cnt_r;
`else
  assign stat_frame_count        = 16'd0;
  assign stat_bad_frame_count    = 16'd0;
  assign stat_preamble_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_ssio_sdr_rx_capture.sv
// Self-checking bench for ssio_sdr_rx_capture: frame table plus scoreboard with latency check.
module tb_ssio_sdr_rx_capture;

`ifdef SSIO_SDR_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  input_d;
  logic        input_dv;
  logic        input_er;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [15:0] stat_frame_count, stat_bad_frame_count, stat_preamble_err_count;

  logic [7:0]  d0_tdata, d2_tdata;
  logic        d0_tvalid, d0_tlast, d0_tuser, d2_tvalid, d2_tlast, d2_tuser;
  logic [15:0] d0_sf, d0_sb, d0_sp, d2_sf, d2_sb, d2_sp;

  always #5 clk = ~clk;

  ssio_sdr_rx_capture #(.WIDTH(8), .SFD(8'hD5), .MIN_PREAMBLE(1)) dut (
    .clk(clk), .rst(rst), .input_d(input_d), .input_dv(input_dv), .input_er(input_er),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .stat_frame_count(stat_frame_count),
    .stat_bad_frame_count(stat_bad_frame_count), .stat_preamble_err_count(stat_preamble_err_count));

  ssio_sdr_rx_capture #(.WIDTH(8), .SFD(8'hD5), .MIN_PREAMBLE(0)) dut0 (
    .clk(clk), .rst(rst), .input_d(input_d), .input_dv(input_dv), .input_er(input_er),
    .m_axis_tdata(d0_tdata), .m_axis_tvalid(d0_tvalid), .m_axis_tlast(d0_tlast),
    .m_axis_tuser(d0_tuser), .stat_frame_count(d0_sf),
    .stat_bad_frame_count(d0_sb), .stat_preamble_err_count(d0_sp));

  ssio_sdr_rx_capture #(.WIDTH(8), .SFD(8'hD5), .MIN_PREAMBLE(2)) dut2 (
    .clk(clk), .rst(rst), .input_d(input_d), .input_dv(input_dv), .input_er(input_er),
    .m_axis_tdata(d2_tdata), .m_axis_tvalid(d2_tvalid), .m_axis_tlast(d2_tlast),
    .m_axis_tuser(d2_tuser), .stat_frame_count(d2_sf),
    .stat_bad_frame_count(d2_sb), .stat_preamble_err_count(d2_sp));

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         due;
  } exp_t;

  typedef struct {
    int         npre;
    bit         bad_lead;
    int         len;
    logic [7:0] first;
    int         err_idx;
    int         gap;
    bit         gap_er;
    bit         accept;
    bit         chk;
    int         d_good;
    int         d_bad;
    int         d_pre;
  } vec_t;

  exp_t sbq[$];
  int   edge_cnt = 0;
  int   n_total  = 0;
  int   n_pass   = 0;
  int   n0_strobes = 0;
  int   n2_strobes = 0;
  int   exp_good = 0, exp_bad = 0, exp_pre = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (d0_tvalid) n0_strobes <= n0_strobes + 1;
    if (d2_tvalid) n2_strobes <= n2_strobes + 1;
  end

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_cnt);
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    @(negedge clk);
    input_d  = d;
    input_dv = dv;
    input_er = er;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        if (sbq.size() == 0) begin
          check(1'b0, "unexpected_strobe", m_axis_tdata, 0);
        end else begin
          e = sbq.pop_front();
          check(m_axis_tdata == e.data, "tdata", m_axis_tdata, e.data);
          check(m_axis_tlast == e.last, "tlast", m_axis_tlast, e.last);
          if (e.last) check(m_axis_tuser == e.user, "tuser", m_axis_tuser, e.user);
          check(edge_cnt == e.due, "latency", edge_cnt, e.due);
        end
      end else if (sbq.size() != 0 && sbq[0].due <= edge_cnt) begin
        e = sbq.pop_front();
        check(1'b0, "missing_strobe", 0, e.data);
      end
    end
  endtask

  task automatic send_frame(input int npre, input bit bad_lead, input int len, input logic [7:0] first,
                            input int err_idx, input int gap, input bit gap_er, input bit accept);
    exp_t e;
    logic [7:0] b;
    if (bad_lead) drive(8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < len; i++) begin
      b = first + 8'(i);
      drive(b, 1'b1, (i == err_idx));
      if (accept) begin
        e.data = b;
        e.last = (i == len - 1);
        e.user = (err_idx >= 0) && (err_idx < len);
        e.due  = edge_cnt + 3;
        sbq.push_back(e);
      end
    end
    for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, gap_er);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_stats(input string tag);
    check(stat_frame_count == (STATS ? 16'(exp_good) : 16'd0), {tag, "_frame_count"}, stat_frame_count, exp_good);
    check(stat_bad_frame_count == (STATS ? 16'(exp_bad) : 16'd0), {tag, "_bad_count"}, stat_bad_frame_count, exp_bad);
    check(stat_preamble_err_count == (STATS ? 16'(exp_pre) : 16'd0), {tag, "_pre_count"}, stat_preamble_err_count, exp_pre);
  endtask

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    int s0, s2, r;
    exp_t e;
    //          npre lead len first   err gap ger acc chk  g  b  p
    vecs[0]  = '{7, 1'b0, 64, 8'h01, -1, 4, 1'b0, 1'b1, 1'b1, 1, 0, 0};
    vecs[1]  = '{7, 1'b0, 64, 8'h01,  9, 4, 1'b0, 1'b1, 1'b1, 0, 1, 0};
    vecs[2]  = '{7, 1'b1,  8, 8'h10, -1, 4, 1'b0, 1'b0, 1'b1, 0, 0, 1};
    vecs[3]  = '{7, 1'b0,  8, 8'h20, -1, 4, 1'b1, 1'b1, 1'b1, 1, 0, 0};
    vecs[4]  = '{7, 1'b0, 16, 8'h30, -1, 1, 1'b0, 1'b1, 1'b0, 1, 0, 0};
    vecs[5]  = '{7, 1'b0, 16, 8'h40, -1, 4, 1'b0, 1'b1, 1'b1, 1, 0, 0};
    vecs[6]  = '{1, 1'b0,  5, 8'h60, -1, 4, 1'b0, 1'b1, 1'b1, 1, 0, 0};
    vecs[7]  = '{0, 1'b0,  4, 8'h70, -1, 4, 1'b0, 1'b0, 1'b1, 0, 0, 1};
    vecs[8]  = '{7, 1'b0,  1, 8'h7A, -1, 4, 1'b0, 1'b1, 1'b1, 1, 0, 0};
    vecs[9]  = '{7, 1'b0,  0, 8'h00, -1, 4, 1'b0, 1'b1, 1'b1, 0, 1, 0};
    vecs[10] = '{7, 1'b0,  4, 8'h80,  3, 4, 1'b0, 1'b1, 1'b1, 0, 1, 0};

    rst = 1'b1; input_d = 8'h00; input_dv = 1'b0; input_er = 1'b0;
    fork monitor(); join_none
    idle(3);
    check(m_axis_tvalid == 1'b0 && m_axis_tlast == 1'b0 && m_axis_tuser == 1'b0, "reset_ctrl",
          {m_axis_tvalid, m_axis_tlast, m_axis_tuser}, 0);
    check(m_axis_tdata == 8'h00, "reset_tdata", m_axis_tdata, 0);
    check_stats("reset");
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < NV; v++) begin
      send_frame(vecs[v].npre, vecs[v].bad_lead, vecs[v].len, vecs[v].first, vecs[v].err_idx,
                 vecs[v].gap, vecs[v].gap_er, vecs[v].accept);
      exp_good += vecs[v].d_good;
      exp_bad  += vecs[v].d_bad;
      exp_pre  += vecs[v].d_pre;
      if (vecs[v].chk) begin
        idle(2);
        check_stats($sformatf("vec%0d", v));
      end
    end

    // MIN_PREAMBLE boundaries on the 0 and 2 variants after a common reset.
    idle(4);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    exp_good = 0; exp_bad = 0; exp_pre = 0;
    idle(2);
    s0 = n0_strobes; s2 = n2_strobes;
    send_frame(1, 1'b0, 3, 8'h81, -1, 4, 1'b0, 1'b1);
    idle(2);
    exp_good = 1;
    check(n2_strobes - s2 == 0, "min2_short_pre_strobes", n2_strobes - s2, 0);
    check(d2_sp == (STATS ? 16'd1 : 16'd0), "min2_pre_count", d2_sp, 1);
    check(n0_strobes - s0 == 3, "min0_with_pre_strobes", n0_strobes - s0, 3);
    s0 = n0_strobes;
    send_frame(0, 1'b0, 4, 8'h91, -1, 4, 1'b0, 1'b0);
    idle(2);
    exp_pre = 1;
    check(n0_strobes - s0 == 4, "min0_bare_sfd_strobes", n0_strobes - s0, 4);
    check(d0_sf == (STATS ? 16'd2 : 16'd0), "min0_frame_count", d0_sf, 2);
    check(d2_sp == (STATS ? 16'd2 : 16'd0), "min2_pre_count2", d2_sp, 2);
    check_stats("min_pre");

    // Reset pulse on payload byte 20 of a 60-byte frame.
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      drive(8'(i + 1), 1'b1, 1'b0);
      if (i < 19) begin
        rst = 1'b0;
        e.data = 8'(i + 1); e.last = 1'b0; e.user = 1'b0; e.due = edge_cnt + 3;
        sbq.push_back(e);
      end else if (i == 19) begin
        rst = 1'b1;
        r = edge_cnt + 1;
        while (sbq.size() != 0 && sbq[$].due >= r) e = sbq.pop_back();
      end else begin
        rst = 1'b0;
        if (i == 20) begin
          check(m_axis_tvalid == 1'b0 && m_axis_tlast == 1'b0, "rst_mid_ctrl",
                {m_axis_tvalid, m_axis_tlast}, 0);
          check(m_axis_tdata == 8'h00, "rst_mid_tdata", m_axis_tdata, 0);
        end
      end
    end
    idle(6);
    exp_good = 0; exp_bad = 0; exp_pre = 1;
    check_stats("rst_mid");
    send_frame(7, 1'b0, 12, 8'hA0, -1, 4, 1'b0, 1'b1);
    idle(2);
    exp_good = 1;
    check_stats("after_rst");

    idle(8);
    check(sbq.size() == 0, "drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ssio_sdr_rx_capture.md
# ssio_sdr_rx_capture

- Receive-side counterpart of the source-synchronous SDR output path; captures a GMII-style SDR bus on its forwarded clock.
- Strips preamble and SFD, then delivers payload as a non-backpressurable AXI-stream with end-of-frame and bad-frame marking.
- Sits between the input clock buffer and the MAC receive logic; all logic runs in the forwarded receive clock domain.

## Interface

- `WIDTH`, default 8: data bus width in bits.
- `SFD`, default 8'hD5: start-of-frame delimiter value.
- `MIN_PREAMBLE`, default 1: minimum 8'h55 bytes required before SFD; range 0..7.

- `clk`  in  1  forwarded receive clock, already buffered; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `input_d`  in  WIDTH  pad data.
- `input_dv`  in  1  pad data-valid.
- `input_er`  in  1  pad receive-error.
- `m_axis_tdata`  out  WIDTH  payload byte.
- `m_axis_tvalid`  out  1  one-cycle strobe per byte.
- `m_axis_tlast`  out  1  last payload byte of the frame.
- `m_axis_tuser`  out  1  frame bad; valid only with tlast.
- `stat_frame_count`  out  16  good frames, saturating.
- `stat_bad_frame_count`  out  16  bad frames, saturating.
- `stat_preamble_err_count`  out  16  preamble/SFD errors, saturating.

## Operation

- Capture stage: `input_d`, `input_dv` and `input_er` are registered with IOB packing into `d_q`, `dv_q` and `er_q`; all reset to 0.
- FSM states, evaluated on the capture registers:
  - IDLE: `!dv_q` stays in IDLE.
    - `d_q==8'h55`: go to PREAMBLE, cnt=1.
    - `d_q==SFD` with `MIN_PREAMBLE==0`: go to PAYLOAD.
    - Any other value: go to DROP, preamble error.
  - PREAMBLE:
    - 8'h55: cnt++, saturating at 7.
    - SFD with cnt≥MIN_PREAMBLE: go to PAYLOAD, clear err_acc.
    - `!dv_q`: go to IDLE, preamble error.
    - Anything else, or SFD with cnt too low: go to DROP, preamble error.
  - PAYLOAD:
    - Each `dv_q` byte loads a one-byte hold register.
    - If the hold register is already full, its byte is emitted first with tlast=0.
    - `er_q` sets err_acc.
    - On `!dv_q` with hold full: emit the held byte with tlast=1 and tuser=err_acc, then go to IDLE.
    - On `!dv_q` with hold empty (SFD then end): no output, bad frame counted, go to IDLE.
  - DROP: wait for `!dv_q`, then go to IDLE. Bytes are discarded.
- `er_q` with `dv_q` low (carrier extension, false carrier) is ignored in all states.
- There is no tready; the downstream consumer must accept every strobe.
- Reset mid-frame:
  - All state clears and outputs drop to 0 in the cycle after `rst` is sampled.
  - The partial frame is lost; no tlast is emitted for it.
  - If `dv_q` is high after reset, the FSM goes to DROP via IDLE and counts a preamble error unless the byte is 8'h55 or SFD.

## Timing

- Reset value of every output: 0.
- A payload byte sampled at the pins on edge k appears on `m_axis_*` after edge k+2. This holds for every byte, including the last.
- `m_axis_tvalid` is high for exactly one cycle per byte. Inside a frame, strobes are contiguous if the pin bytes are contiguous.
- Back-to-back frames separated by one `dv` low cycle are accepted. The tlast of frame N and the first payload strobe of frame N+1 are separated by at least preamble+SFD+1 cycles.
- Counters update on the cycle after the tlast or error event.

## Configuration

- Macro: `SSIO_SDR_RX_STATS_EN`.
- Defined: the three 16-bit saturating counters are built and cleared by `rst`.
  - Good frame: tlast with tuser=0.
  - Bad frame: tlast with tuser=1, or an empty payload.
- Undefined: counter logic is omitted and the three `stat_*` ports are tied to 0. Stream behaviour is identical either way.

## Test plan

- 7×8'h55, 8'hD5, payload 8'h01..8'h40 (64 bytes), dv low → 64 strobes, data 01..40, tlast only on 8'h40, tuser=0, first strobe 2 cycles after the 8'h01 pin sample; frame count=1.
- Same frame with `input_er` high on payload byte 10 → 64 strobes, tlast with tuser=1; bad count=1, frame count=0.
- `dv` high with 8'hAA first, then 8'h55/8'hD5/data, then dv low → no strobes; preamble error count=1; DROP held until dv low; the next good frame is received normally.
- `MIN_PREAMBLE`=2, 1×8'h55 then SFD → frame dropped, preamble error=1. Repeat with `MIN_PREAMBLE`=0 and bare SFD+4 bytes → 4 strobes.
- Two 16-byte frames with a one-cycle dv gap → 32 strobes, two tlasts, no merged or lost bytes.
- `rst` pulsed for 1 cycle at payload byte 20 of 60 → outputs 0 the next cycle, no tlast for that frame, no counter increment; the following frame is received intact.
